// File: rtl/autocorr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | autocorr_pkg: shared types, widths and saturation for the lag    |
// | sequencer.  Rev 1.0                                              |
// +------------------------------------------------------------------+
package autocorr_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int ACC_W         = 32;
    localparam int PREEMPH_SHIFT = 4;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_OUTPUT = 3'd4
    } state_t;

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAMPLE_W:0] v);
        if (v > 17'sd32767) begin
            return 16'sh7fff;
        end else if (v < -17'sd32768) begin
            return 16'sh8000;
        end else begin
            return $signed(v[SAMPLE_W-1:0]);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/autocorr_lag_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | autocorr_lag_sequencer_if: sample in, MAD operands, result out.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface autocorr_lag_sequencer_if #(
    parameter int LAG_W = 4
);
    import autocorr_pkg::*;

    logic                       s_valid;
    logic                       s_ready;
    logic signed [SAMPLE_W-1:0] s_data;
    logic                       mad_rst;
    logic signed [SAMPLE_W-1:0] mad_x;
    logic signed [SAMPLE_W-1:0] mad_xl;
    logic signed [ACC_W-1:0]    mad_y;
    logic                       r_valid;
    logic                       r_ready;
    logic [LAG_W-1:0]           r_lag;
    logic signed [ACC_W-1:0]    r_data;
    logic                       frame_done;

    // master is the sequencer, slave is its environment (source, MAD, sink)
    modport master (
        input  s_valid, s_data, mad_y, r_ready,
        output s_ready, mad_rst, mad_x, mad_xl, r_valid, r_lag, r_data, frame_done
    );

    modport slave (
        output s_valid, s_data, mad_y, r_ready,
        input  s_ready, mad_rst, mad_x, mad_xl, r_valid, r_lag, r_data, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/autocorr_frame_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | autocorr_frame_ram: one write port, two registered read ports.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module autocorr_frame_ram
    import autocorr_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic signed [SAMPLE_W-1:0] wdata,
    input  logic [AW-1:0]              raddr_a,
    input  logic [AW-1:0]              raddr_b,
    output logic signed [SAMPLE_W-1:0] rdata_a,
    output logic signed [SAMPLE_W-1:0] rdata_b
);

    logic signed [SAMPLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end

endmodule
`default_nettype wire

// File: rtl/autocorr_lag_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | autocorr_lag_sequencer: buffers a frame, streams lag pairs to    |
// | the MAD. Rev 1.0; AUTOCORR_PREEMPH_EN = pre-emphasis on load     |
// +------------------------------------------------------------------+
module autocorr_lag_sequencer
    import autocorr_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int ORDER     = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    autocorr_lag_sequencer_if.master bus
);

    localparam int AW    = $clog2(FRAME_LEN);
    localparam int LAG_W = $clog2(ORDER + 1);
    localparam logic [AW-1:0]    LAST_IDX = AW'(FRAME_LEN - 1);
    localparam logic [LAG_W-1:0] LAST_LAG = LAG_W'(ORDER);

    state_t                     state;
    state_t                     state_next;
    logic [AW-1:0]              wptr;
    logic [AW-1:0]              pos;
    logic [AW-1:0]              pos_last;
    logic [AW-1:0]              raddr_a;
    logic [AW-1:0]              raddr_b;
    logic [LAG_W-1:0]           lag;
    logic signed [SAMPLE_W-1:0] wr_data;
    logic signed [SAMPLE_W-1:0] rd_a;
    logic signed [SAMPLE_W-1:0] rd_b;
    logic                       load_beat;
    logic                       accept;
    logic                       s_ready;
    logic                       mad_rst;
    logic signed [SAMPLE_W-1:0] mad_x;
    logic signed [SAMPLE_W-1:0] mad_xl;
    logic                       r_valid;
    logic [LAG_W-1:0]           r_lag;
    logic signed [ACC_W-1:0]    r_data;
    logic                       frame_done;

    assign load_beat = bus.s_valid && s_ready;
    assign accept    = (state == ST_OUTPUT) && r_valid && bus.r_ready;
    // pos counts presented pairs (n - lag); the last one is FRAME_LEN-1-lag
    assign pos_last  = LAST_IDX - AW'(lag);
    assign raddr_a   = raddr_b + AW'(lag);

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        mad_rst    = 1'b0;
        mad_x      = '0;
        mad_xl     = '0;
        raddr_b    = '0;
        unique case (state)
            ST_LOAD: begin
                s_ready = 1'b1;
                mad_rst = 1'b1;
                if (bus.s_valid && (wptr == LAST_IDX)) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mad_rst    = 1'b1;
                state_next = ST_STREAM;
            end
            ST_STREAM: begin
                // operands are the reads issued a cycle earlier; issue the next pair now
                mad_x   = rd_a;
                mad_xl  = rd_b;
                raddr_b = pos + AW'(1);
                if (pos == pos_last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (accept) begin
                    state_next = (lag == LAST_LAG) ? ST_LOAD : ST_CLEAR;
                end
            end
            default: begin
                state_next = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_LOAD;
            wptr       <= '0;
            pos        <= '0;
            lag        <= '0;
            r_valid    <= 1'b0;
            r_lag      <= '0;
            r_data     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            frame_done <= accept && (lag == LAST_LAG);
            if (load_beat) begin
                wptr <= wptr + AW'(1);
            end
            if (state == ST_CLEAR) begin
                pos <= '0;
            end else if (state == ST_STREAM) begin
                pos <= pos + AW'(1);
            end
            if (state == ST_FLUSH) begin
                r_valid <= 1'b1;
                r_data  <= bus.mad_y;
                r_lag   <= lag;
            end else if (accept) begin
                r_valid <= 1'b0;
                lag     <= (lag == LAST_LAG) ? '0 : lag + LAG_W'(1);
            end
        end
    end

`ifdef AUTOCORR_PREEMPH_EN
    logic signed [SAMPLE_W-1:0] prev_s;
    logic signed [SAMPLE_W-1:0] prev_sh;
    logic [SAMPLE_W:0]          emph;

    // x'[n] = s[n] - s[n-1] + s[n-1]/16, worked in 17 bits then clamped
    assign prev_sh = prev_s >>> PREEMPH_SHIFT;
    assign emph    = {bus.s_data[SAMPLE_W-1], bus.s_data}
                   - {prev_s[SAMPLE_W-1], prev_s}
                   + {prev_sh[SAMPLE_W-1], prev_sh};
    assign wr_data = sat16($signed(emph));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_s <= '0;
        end else if (load_beat) begin
            prev_s <= (wptr == LAST_IDX) ? '0 : bus.s_data;
        end
    end
`else
    assign wr_data = bus.s_data;
`endif

    autocorr_frame_ram #(
        .DEPTH (FRAME_LEN),
        .AW    (AW)
    ) u_frame_ram (
        .clk     (clk),
        .we      (load_beat),
        .waddr   (wptr),
        .wdata   (wr_data),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    assign bus.s_ready    = s_ready;
    assign bus.mad_rst    = mad_rst;
    assign bus.mad_x      = mad_x;
    assign bus.mad_xl     = mad_xl;
    assign bus.r_valid    = r_valid;
    assign bus.r_lag      = r_lag;
    assign bus.r_data     = r_data;
    assign bus.frame_done = frame_done;

endmodule
`default_nettype wire

// File: tb/tb_autocorr_lag_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_autocorr_lag_sequencer: directed vectors, FRAME_LEN=8 ORDER=2 |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_autocorr_lag_sequencer;

    typedef logic signed [15:0] frame_t [8];
    typedef int res_t [3];
    typedef struct {
        frame_t x;
        res_t   expd;
        bit     gaps;
        int     stall_lag;
        bit     early;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cycle = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t vecs [6];

    autocorr_lag_sequencer_if #(.LAG_W(2)) bus ();

    autocorr_lag_sequencer #(
        .FRAME_LEN (8),
        .ORDER     (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // MAD stand-in: clears on mad_rst, otherwise accumulates x*xl; y reads sum/20
    longint acc = 0;
    always @(posedge clk) begin
        if (bus.mad_rst) acc <= 0;
        else             acc <= acc + longint'(bus.mad_x) * longint'(bus.mad_xl);
    end
    assign bus.mad_y = 32'(acc / 20);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic stored_of(input frame_t s, output frame_t y);
        int prev = 0;
        int t;
        for (int i = 0; i < 8; i++) begin
`ifdef AUTOCORR_PREEMPH_EN
            t = int'(s[i]) - prev + (prev >>> 4);
            if (t > 32767) t = 32767;
            if (t < -32768) t = -32768;
            y[i] = 16'(t);
            prev = int'(s[i]);
`else
            y[i] = s[i];
`endif
        end
    endtask

    function automatic int golden(input frame_t s, input int k);
        longint sum = 0;
        for (int n = k; n < 8; n++) sum += longint'(s[n]) * longint'(s[n-k]);
        return int'(sum / 20);
    endfunction

    task automatic load_frame(input frame_t x, input bit gaps);
        int i = 0;
        int guard = 0;
        bit v;
        bit rdy;
        bit early = 0;
        while (i < 8 && guard < 200) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_valid = v;
            bus.s_data  = v ? x[i] : 16'sh7abc;
            rdy = bus.s_ready;
            if (!rdy) early = 1;
            step();
            if (v && rdy) i++;
            guard++;
        end
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        check("load_beats", i, 8);
        check("load_sready_held", early, 0);
    endtask

    task automatic run_frame(input int id, input frame_t x, input res_t expd, input bit gaps,
                             input int stall_lag, input bit early);
        frame_t st;
        res_t   e;
        int t0;
        int w;
        bit sready_bad = 0;
        bit unstable = 0;
        bit clr_seen = 0;
        logic signed [31:0] hd;
        logic [1:0] hl;
        stored_of(x, st);
`ifdef AUTOCORR_PREEMPH_EN
        for (int k = 0; k < 3; k++) e[k] = golden(st, k);
`else
        e = expd;
`endif
        load_frame(x, gaps);
        t0 = cycle;
        check($sformatf("v%0d_sready_after_load", id), bus.s_ready, 0);
        w = 0;
        while (bus.mad_rst && w < 5) begin step(); w++; end
        check($sformatf("v%0d_stream_start", id), bus.mad_rst, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("v%0d_lag0_x%0d", id, i), bus.mad_x, st[i]);
            check($sformatf("v%0d_lag0_xl%0d", id, i), bus.mad_xl, st[i]);
            step();
        end
        check($sformatf("v%0d_flush_x", id), bus.mad_x, 0);
        for (int k = 0; k < 3; k++) begin
            w = 0;
            bus.r_ready = early;
            while (!bus.r_valid && w < 50) begin
                step();
                w++;
                if (bus.s_ready) sready_bad = 1;
            end
            bus.r_ready = 1'b0;
            check($sformatf("v%0d_lag%0d_valid", id, k), bus.r_valid, 1);
            check($sformatf("v%0d_lag%0d_latency", id, k), cycle - t0, 10 - k);
            check($sformatf("v%0d_lag%0d_rlag", id, k), bus.r_lag, k);
            check($sformatf("v%0d_lag%0d_data", id, k), bus.r_data, e[k]);
            if (k == stall_lag) begin
                hd = bus.r_data;
                hl = bus.r_lag;
                repeat (20) begin
                    step();
                    if (bus.r_valid !== 1'b1 || bus.r_data !== hd || bus.r_lag !== hl) unstable = 1;
                    if (bus.mad_rst !== 1'b0 || bus.mad_x !== 16'sd0) clr_seen = 1;
                end
                check($sformatf("v%0d_stall_stable", id), unstable, 0);
                check($sformatf("v%0d_stall_idle_mad", id), clr_seen, 0);
            end
            bus.r_ready = 1'b1;
            step();
            bus.r_ready = 1'b0;
            t0 = cycle;
            if (k < 2) begin
                check($sformatf("v%0d_lag%0d_valid_drop", id, k), bus.r_valid, 0);
                check($sformatf("v%0d_lag%0d_no_done", id, k), bus.frame_done, 0);
            end else begin
                check($sformatf("v%0d_frame_done", id), bus.frame_done, 1);
                step();
                check($sformatf("v%0d_frame_done_pulse", id), bus.frame_done, 0);
                check($sformatf("v%0d_sready_low_in_frame", id), sready_bad, 0);
                check($sformatf("v%0d_sready_back", id), bus.s_ready, 1);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mad_rst"}, bus.mad_rst, 1);
        check({tag, "_mad_x"}, bus.mad_x, 0);
        check({tag, "_mad_xl"}, bus.mad_xl, 0);
        check({tag, "_r_valid"}, bus.r_valid, 0);
        check({tag, "_r_data"}, bus.r_data, 0);
        check({tag, "_r_lag"}, bus.r_lag, 0);
        check({tag, "_frame_done"}, bus.frame_done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        vecs[0].x = '{16'sd256, 16'sd256, 16'sd256, 16'sd256, 16'sd256, 16'sd256, 16'sd256, 16'sd256};
        vecs[0].expd = '{26214, 22937, 19660};
        vecs[0].gaps = 0; vecs[0].stall_lag = -1; vecs[0].early = 0;
        vecs[1].x = '{16'sd16384, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        vecs[1].expd = '{13421772, 0, 0};
        vecs[1].gaps = 0; vecs[1].stall_lag = -1; vecs[1].early = 1;
        vecs[2].x = vecs[0].x;
        vecs[2].expd = vecs[0].expd;
        vecs[2].gaps = 0; vecs[2].stall_lag = 1; vecs[2].early = 0;
        vecs[3].x = '{16'sd100, -16'sd100, 16'sd100, -16'sd100, 16'sd100, -16'sd100, 16'sd100, -16'sd100};
        vecs[3].expd = '{4000, -3500, 3000};
        vecs[3].gaps = 1; vecs[3].stall_lag = -1; vecs[3].early = 0;
        vecs[4].x = '{16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000, 16'sd5000, 16'sd6000, 16'sd7000, 16'sd8000};
        vecs[4].expd = '{10200000, 8400000, 6650000};
        vecs[4].gaps = 1; vecs[4].stall_lag = -1; vecs[4].early = 0;
        vecs[5].x = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
        vecs[5].expd = '{429496729, 375809638, 322122547};
        vecs[5].gaps = 0; vecs[5].stall_lag = -1; vecs[5].early = 0;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.r_ready = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        check("reset_s_ready", bus.s_ready, 1);
        check_reset_outputs("reset");

        for (int v = 0; v < 6; v++) begin
            run_frame(v, vecs[v].x, vecs[v].expd, vecs[v].gaps, vecs[v].stall_lag, vecs[v].early);
        end

        // reset in the middle of the lag-1 stream, then a clean frame
        load_frame(vecs[0].x, 1'b0);
        w = 0;
        while (!bus.r_valid && w < 50) begin step(); w++; end
        check("mid_lag0_valid", bus.r_valid, 1);
        bus.r_ready = 1'b1;
        step();
        bus.r_ready = 1'b0;
        repeat (3) step();
        check("mid_streaming", bus.mad_rst, 0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        check("midreset_s_ready", bus.s_ready, 1);
        run_frame(6, vecs[0].x, vecs[0].expd, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/autocorr_lag_sequencer.md
Name: autocorr_lag_sequencer

Overview:
- Front-end sequencer that drives autocorrelation_mad, the existing multiply-accumulate block of the LPC analysis path.
- Buffers one frame of 16-bit samples, then for each lag k = 0..ORDER clears the MAD and streams the pairs (x[n], x[n-k]) for n = k..FRAME_LEN-1.
- Captures the MAD result for each lag and presents it as a valid/ready stream to the Levinson-Durbin stage.

Parameters:
- FRAME_LEN, 256, samples per frame (power of 2, ≥ 4).
- ORDER, 10, highest lag computed (ORDER < FRAME_LEN); ORDER+1 results per frame.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  sequencer accepts a sample; high only in LOAD.
- s_data  in  16  signed input sample.
- mad_rst  out  1  active-high synchronous clear to the MAD's reset.
- mad_x  out  16  signed operand x to the MAD.
- mad_xl  out  16  signed operand x_lagged to the MAD.
- mad_y  in  32  signed MAD output y.
- r_valid  out  1  result valid.
- r_ready  in  1  result accepted.
- r_lag  out  $clog2(ORDER+1)  lag index of r_data.
- r_data  out  32  signed autocorrelation value for r_lag.
- frame_done  out  1  one-cycle pulse after lag ORDER is accepted.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = LOAD, write pointer and lag = 0.
  - s_ready = 1 once out of reset.
  - mad_rst = 1; mad_x, mad_xl, r_data, r_lag = 0.
  - r_valid, frame_done = 0.
  - Reset mid-frame discards the partial frame and any unaccepted result.
- LOAD:
  - Each s_valid & s_ready beat writes s_data to buffer[wptr], then wptr++.
  - The beat that writes index FRAME_LEN-1 moves the FSM to CLEAR.
  - s_ready is low in every other state (no double buffering).
- CLEAR (1 cycle):
  - mad_rst = 1, mad_x = mad_xl = 0.
  - Read addresses n = k and n-k = 0 are issued.
- STREAM (FRAME_LEN-k cycles):
  - The buffer has two synchronous read ports with 1-cycle latency, so operands arrive one cycle after their addresses.
  - mad_rst = 0; mad_x = buffer[n], mad_xl = buffer[n-k], exactly once per pair, no gaps.
  - After the last pair the FSM moves to FLUSH.
- FLUSH (1 cycle):
  - mad_x = mad_xl = 0; the MAD accumulates nothing, so mad_y holds the final value.
  - r_data ← mad_y, r_lag ← k, r_valid ← 1.
- OUTPUT:
  - r_valid, r_data and r_lag are held stable until r_ready.
  - On r_valid & r_ready: if k == ORDER, pulse frame_done, set k = 0 and go to LOAD. Otherwise k++ and go to CLEAR.
  - r_ready asserted while r_valid is low is ignored.
- Outside STREAM, mad_x and mad_xl are always 0. The MAD has no enable, so this is required.
- Lag ORDER streams FRAME_LEN-ORDER pairs, which is ≥ 1.
- Frame processing time: (ORDER+1)·3 + Σ(FRAME_LEN-k) cycles, plus r_ready stalls.

Optional Feature:
- AUTOCORR_PREEMPH_EN defined: pre-emphasis is applied on load.
  - Stored value: x'[n] = sat16(s[n] - s[n-1] + (s[n-1] >>> 4)), alpha = 15/16.
  - s[-1] = 0 at the start of each frame.
  - A 17-bit intermediate saturates to [-32768, 32767].
- Macro undefined: samples are stored unmodified.

Decomposition:
- Package autocorr_pkg:
  - State enum (LOAD, CLEAR, STREAM, FLUSH, OUTPUT).
  - SAMPLE_W = 16, ACC_W = 32, PREEMPH_SHIFT = 4.
  - sat16 function.
- Sub-module autocorr_frame_ram: one write port and two synchronous read ports, depth FRAME_LEN.

Test Plan (FRAME_LEN = 8, ORDER = 2, real autocorrelation_mad attached):
- Eight samples of 256 → r_data = 26214 (lag 0), 22937 (lag 1), 19660 (lag 2); frame_done pulses once after lag 2.
- Impulse: s[0] = 16384, rest 0 → lag 0 = 13421772; lags 1 and 2 = 0.
- r_ready held low 20 cycles on lag 1 → r_valid, r_data and r_lag stay stable and no mad_rst pulse occurs until acceptance.
- s_valid toggled randomly in LOAD → exactly 8 writes; no CLEAR before the 8th beat; s_ready stays low until frame_done.
- reset_n low mid-STREAM of lag 1 → all outputs at reset values immediately; a fresh frame then yields the first scenario's values.
- AUTOCORR_PREEMPH_EN with eight samples of 256 → stored {256, 16, 16, 16, 16, 16, 16, 16}; results match the golden model.
